// File: rtl/inst_fetch_pkg.sv
// rtl/inst_fetch_pkg.sv - shared bus widths, reset level and fetch state encodings
package inst_fetch_pkg;

  localparam int          INST_ADDR_BUS = 32;
  localparam int          INST_BUS      = 32;
  localparam logic [31:0] ZERO_WORD     = 32'h0000_0000;
  localparam logic        RST_ENABLE    = 1'b0;

  typedef enum logic [1:0] {
    FS_IDLE = 2'd0,
    FS_REQ  = 2'd1,
    FS_WAIT = 2'd2,
    FS_HOLD = 2'd3
  } fetch_state_e;

endpackage

// File: rtl/fetch_skid_buf.sv
// rtl/fetch_skid_buf.sv - one-entry {pc, inst} holding register for decode back-pressure
module fetch_skid_buf
  import inst_fetch_pkg::*;
#(
  parameter int ADDR_W = INST_ADDR_BUS,
  parameter int DATA_W = INST_BUS
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic              rd_en,
  input  logic              clr,
  input  logic [ADDR_W-1:0] wr_pc,
  input  logic [DATA_W-1:0] wr_inst,
  output logic              full,
  output logic [ADDR_W-1:0] rd_pc,
  output logic [DATA_W-1:0] rd_inst
);

  logic              full_q;
  logic [ADDR_W-1:0] pc_q;
  logic [DATA_W-1:0] inst_q;

  // clr wins so a redirect never lets a stale entry reach decode
  always_ff @(posedge clk or negedge rst) begin
    if (rst == RST_ENABLE) begin
      full_q <= 1'b0;
      pc_q   <= '0;
      inst_q <= '0;
    end else if (clr) begin
      full_q <= 1'b0;
    end else if (wr_en) begin
      full_q <= 1'b1;
      pc_q   <= wr_pc;
      inst_q <= wr_inst;
    end else if (rd_en) begin
      full_q <= 1'b0;
    end
  end

  assign full    = full_q;
  assign rd_pc   = pc_q;
  assign rd_inst = inst_q;

endmodule

// File: rtl/inst_fetch.sv
// rtl/inst_fetch.sv - single-outstanding instruction fetch with decode slot, skid and flush discard
module inst_fetch
  import inst_fetch_pkg::*;
#(
  parameter int ADDR_W = INST_ADDR_BUS,
  parameter int DATA_W = INST_BUS
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] pc,
  output logic              pc_next_en,
  input  logic              flush,
  output logic              inst_req,
  output logic [ADDR_W-1:0] inst_addr,
  input  logic              inst_addr_ok,
  input  logic              inst_data_ok,
  input  logic [DATA_W-1:0] inst_rdata,
  output logic              id_valid,
  input  logic              id_ready,
  output logic [ADDR_W-1:0] id_pc,
  output logic [DATA_W-1:0] id_inst
);

  fetch_state_e      state_q;
  logic              inst_req_q;
  logic              discard_q;
  logic [ADDR_W-1:0] infl_pc_q;
  logic              id_valid_q, id_valid_d;
  logic [ADDR_W-1:0] id_pc_q, id_pc_d;
  logic [DATA_W-1:0] id_inst_q, id_inst_d;
  logic              id_fire, data_in, load_out, skid_wr, skid_rd, skid_full;
  logic [ADDR_W-1:0] skid_pc;
  logic [DATA_W-1:0] skid_inst;

  assign id_fire  = id_valid_q & id_ready;
  assign data_in  = (state_q == FS_WAIT) & inst_data_ok & ~discard_q & ~flush;
  assign load_out = data_in & (~id_valid_q | id_fire);
  assign skid_wr  = data_in & id_valid_q & ~id_fire;
  assign skid_rd  = skid_full & id_fire & ~flush;

  always_ff @(posedge clk or negedge rst) begin
    if (rst == RST_ENABLE) begin
      state_q    <= FS_IDLE;
      inst_req_q <= 1'b0;
      discard_q  <= 1'b0;
      infl_pc_q  <= '0;
    end else begin
      case (state_q)
        FS_IDLE: begin
          state_q    <= FS_REQ;
          inst_req_q <= 1'b1;
        end
        FS_REQ: begin
          if (inst_addr_ok) begin
            infl_pc_q  <= pc;
            discard_q  <= flush;
            state_q    <= FS_WAIT;
            inst_req_q <= 1'b0;
          end
        end
        FS_WAIT: begin
          if (inst_data_ok) begin
            discard_q  <= 1'b0;
            state_q    <= skid_wr ? FS_HOLD : FS_REQ;
            inst_req_q <= ~skid_wr;
          end else if (flush) begin
            discard_q <= 1'b1;
          end
        end
        FS_HOLD: begin
          if (flush || id_fire) begin
            state_q    <= FS_REQ;
            inst_req_q <= 1'b1;
          end
        end
        default: begin
          state_q    <= FS_IDLE;
          inst_req_q <= 1'b0;
        end
      endcase
    end
  end

  // Slot registers move only on a load, a skid refill or a consume
  always_comb begin
    id_valid_d = id_valid_q;
    id_pc_d    = id_pc_q;
    id_inst_d  = id_inst_q;
    if (flush) begin
      id_valid_d = 1'b0;
    end else if (load_out) begin
      id_valid_d = 1'b1;
      id_pc_d    = infl_pc_q;
      id_inst_d  = inst_rdata;
    end else if (skid_rd) begin
      id_valid_d = 1'b1;
      id_pc_d    = skid_pc;
      id_inst_d  = skid_inst;
    end else if (id_fire) begin
      id_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (rst == RST_ENABLE) begin
      id_valid_q <= 1'b0;
      id_pc_q    <= ADDR_W'(ZERO_WORD);
      id_inst_q  <= DATA_W'(ZERO_WORD);
    end else begin
      id_valid_q <= id_valid_d;
      id_pc_q    <= id_pc_d;
      id_inst_q  <= id_inst_d;
    end
  end

  fetch_skid_buf #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_skid (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (skid_wr),
    .rd_en   (skid_rd),
    .clr     (flush),
    .wr_pc   (infl_pc_q),
    .wr_inst (inst_rdata),
    .full    (skid_full),
    .rd_pc   (skid_pc),
    .rd_inst (skid_inst)
  );

  assign inst_req   = inst_req_q;
  assign inst_addr  = pc;
  assign pc_next_en = inst_req_q & inst_addr_ok & ~flush;
  assign id_valid   = id_valid_q;
  assign id_pc      = id_pc_q;
  assign id_inst    = id_inst_q;

endmodule
